am_inserter: RTL and testbench

AM_INSERTER -- requirements
Module: am_inserter

---
 rtl/am_inserter.sv | 120 ++++++++++++
 tb/tb_am_inserter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/am_inserter.sv
// am_inserter: periodic alignment-marker inserter with running BIP for one PCS lane.
//   i_clock, i_reset (sync, active-high), i_am_enable (0 = bypass),
//   i_valid/i_data/o_ready upstream handshake, o_valid/o_data/o_am_flag registered output.
module am_inserter #(
    parameter int NB_BLOCK  = 66,
    parameter int NB_AM     = 48,
    parameter int LANE_ID   = 0,
    parameter int AM_PERIOD = 16383
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_am_enable,
    input  logic                i_valid,
    input  logic [NB_BLOCK-1:0] i_data,
    output logic                o_ready,
    output logic                o_valid,
    output logic [NB_BLOCK-1:0] o_data,
    output logic                o_am_flag
);
    function automatic logic [47:0] am_word(input int lane);
        case (lane)
            0:       return 48'hC168213E97DE;
            1:       return 48'h9D718E628E71;
            2:       return 48'h594BE8A6B417;
            3:       return 48'h4D957BB26A84;
            4:       return 48'hF507090AF8F6;
            5:       return 48'hDD14C222EB3D;
            6:       return 48'h9A4A2665B5D9;
            7:       return 48'h7B456684BA99;
            8:       return 48'hA024765FDB89;
            9:       return 48'h68C9FB973604;
            10:      return 48'hFD6C99029366;
            11:      return 48'hB99155466EAA;
            12:      return 48'h5CB9B2A3464D;
            13:      return 48'h1AF8BDE50742;
            14:      return 48'h83C7CA7C3835;
            15:      return 48'h3536CDCAC932;
            16:      return 48'hC4314C3BCEB3;
            17:      return 48'hADD6B7522948;
            18:      return 48'h5F662AA099D5;
            19:      return 48'hC0F0E53F0F1A;
            default: return 48'h0;
        endcase
    endfunction

    // XOR of the eight payload bytes, sync header folded into bits 4 and 3
    function automatic logic [7:0] bip_of(input logic [NB_BLOCK-1:0] blk);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) r ^= blk[i*8 +: 8];
        r[4] ^= blk[65];
        r[3] ^= blk[64];
        return r;
    endfunction

    if (LANE_ID < 0 || LANE_ID > 19) begin : g_bad_lane
        $error("am_inserter: LANE_ID must be in 0..19");
    end
    if (AM_PERIOD < 1) begin : g_bad_period
        $error("am_inserter: AM_PERIOD must be >= 1");
    end
    if (NB_BLOCK != 66 || NB_AM != 48) begin : g_bad_width
        $error("am_inserter: marker layout needs NB_BLOCK=66 and NB_AM=48");
    end

    localparam int                NB_CNT  = $clog2(AM_PERIOD + 1);
    localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(AM_PERIOD);
    localparam logic [NB_AM-1:0]  AM_WORD = am_word(LANE_ID);

    logic [NB_BLOCK-1:0] o_data_q, o_data_d, marker;
    logic                o_valid_q, o_valid_d, o_am_flag_q, o_am_flag_d;
    logic [NB_CNT-1:0]   cnt_q, cnt_d;
    logic [7:0]          acc_q, acc_d;
    logic                insert_due;

    // cnt parked at CNT_MAX by reset/bypass makes the first enabled slot a marker with BIP3=0
    always_comb begin
        insert_due  = cnt_q == CNT_MAX;
        o_ready     = ~i_reset & (~i_am_enable | ~insert_due);
        marker      = {2'b10, AM_WORD[47:24], acc_q, AM_WORD[23:0], ~acc_q};
        o_data_d    = i_data;
        o_valid_d   = i_valid;
        o_am_flag_d = 1'b0;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        if (!i_am_enable) begin
            cnt_d = CNT_MAX;
            acc_d = 8'h00;
        end else if (insert_due) begin
            o_data_d    = marker;
            o_valid_d   = 1'b1;
            o_am_flag_d = 1'b1;
            cnt_d       = '0;
            acc_d       = bip_of(marker);
        end else if (i_valid) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = acc_q ^ bip_of(i_data);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_data_q    <= '0;
            o_valid_q   <= 1'b0;
            o_am_flag_q <= 1'b0;
            cnt_q       <= CNT_MAX;
            acc_q       <= 8'h00;
        end else begin
            o_data_q    <= o_data_d;
            o_valid_q   <= o_valid_d;
            o_am_flag_q <= o_am_flag_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
        end
    end

    assign o_data    = o_data_q;
    assign o_valid   = o_valid_q;
    assign o_am_flag = o_am_flag_q;
endmodule

// File: tb/tb_am_inserter.sv
// tb_am_inserter: randomized + directed bench for am_inserter (lanes 0 and 5, AM_PERIOD=4).
module tb_am_inserter;
    localparam int P = 4;
    localparam logic [47:0] AMW [2] = '{48'hC168213E97DE, 48'hDD14C222EB3D};

    logic        clk = 1'b0;
    logic        rst, en, vld;
    logic [65:0] din;
    logic        rdy [2];
    logic        ov  [2];
    logic        af  [2];
    logic [65:0] od  [2];

    int checks = 0;
    int errors = 0;

    // model state: transfers since last marker (P = marker owed), running BIP per lane
    int          tr = P;
    logic [7:0]  bp [2] = '{8'h00, 8'h00};
    logic        ev [2], ef [2];
    logic [65:0] ed [2];
    logic [65:0] sb [$];
    int          gap = 0;
    bit          clean = 0;

    always #5 clk = ~clk;

    am_inserter #(.LANE_ID(0), .AM_PERIOD(P)) dut0 (
        .i_clock(clk), .i_reset(rst), .i_am_enable(en), .i_valid(vld), .i_data(din),
        .o_ready(rdy[0]), .o_valid(ov[0]), .o_data(od[0]), .o_am_flag(af[0]));
    am_inserter #(.LANE_ID(5), .AM_PERIOD(P)) dut5 (
        .i_clock(clk), .i_reset(rst), .i_am_enable(en), .i_valid(vld), .i_data(din),
        .o_ready(rdy[1]), .o_valid(ov[1]), .o_data(od[1]), .o_am_flag(af[1]));

    task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bip(input logic [65:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) r ^= b[i*8 +: 8];
        r[4] ^= b[65];
        r[3] ^= b[64];
        return r;
    endfunction

    function automatic logic [65:0] rnd_blk();
        logic [65:0] b;
        b[31:0]  = $urandom;
        b[63:32] = $urandom;
        b[65:64] = 2'($urandom);
        return b;
    endfunction

    task automatic step(input logic r, input logic e, input logic v, input logic [65:0] d);
        logic due;
        rst = r; en = e; vld = v; din = d;
        #1;
        due = (tr == P);
        for (int k = 0; k < 2; k++) chk("ready", 66'(rdy[k]), 66'(!r && (!e || !due)));
        if (r || !e) clean = 0;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                ev[k] = 0; ef[k] = 0; ed[k] = '0; bp[k] = 8'h00;
            end else if (!e) begin
                ev[k] = v; ef[k] = 0; ed[k] = d; bp[k] = 8'h00;
            end else if (due) begin
                ed[k] = {2'b10, AMW[k][47:24], bp[k], AMW[k][23:0], ~bp[k]};
                ev[k] = 1; ef[k] = 1; bp[k] = bip(ed[k]);
            end else begin
                ev[k] = v; ef[k] = 0; ed[k] = d;
                if (v) bp[k] ^= bip(d);
            end
        end
        if (!r && (!e || !due) && v) sb.push_back(d);
        if (r || !e) tr = P;
        else if (due) tr = 0;
        else if (v) tr++;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("valid", 66'(ov[k]), 66'(ev[k]));
            chk("am_flag", 66'(af[k]), 66'(ef[k]));
            if (ev[k] || r) chk("data", od[k], ed[k]);
        end
        if (af[0]) begin
            if (clean) chk("period", 66'(gap), 66'(P));
            clean = 1;
            gap = 0;
        end else if (ov[0]) begin
            gap++;
            if (sb.size() == 0) chk("sb_empty", 66'(1), 66'(0));
            else chk("sb", od[0], sb.pop_front());
        end
        if (r) sb.delete();
    endtask

    initial begin
        logic [65:0] zb, fb;
        zb = {2'b01, 64'h0};
        fb = {2'b01, 64'h00000000000000FF};
        for (int i = 0; i < 3; i++) step(1, 1, 1, rnd_blk());
        chk("rst_data", od[0], 66'h0);
        // first slot after reset is a bare marker
        step(0, 1, 0, rnd_blk());
        chk("first_am", od[0], {2'b10, 64'hC1682100_3E97DEFF});
        step(0, 1, 1, fb);
        for (int i = 0; i < 3; i++) step(0, 1, 1, zb);
        step(0, 1, 0, zb);
        chk("bip3_ef", 66'(od[0][39:32]), 66'h0EF);
        chk("bip7_10", 66'(od[0][7:0]), 66'h010);
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 4; i++) step(0, 1, 1, zb);
            step(0, 1, 0, zb);
            chk("bip3_10", 66'(od[0][39:32]), 66'h010);
            chk("bip7_ef", 66'(od[0][7:0]), 66'h0EF);
        end
        for (int i = 0; i < 200; i++) step(0, 1, 1'($urandom), rnd_blk());
        // enable dropped mid-period, lane 5
        step(1, 1, 0, zb);
        step(0, 1, 0, zb);
        step(0, 1, 1, rnd_blk());
        step(0, 1, 1, rnd_blk());
        for (int i = 0; i < 3; i++) begin
            fb = rnd_blk();
            step(0, 0, 1, fb);
            chk("bypass", od[1], fb);
        end
        step(0, 1, 0, zb);
        chk("reenable_l5", od[1], {2'b10, 64'hDD14C200_22EB3DFF});
        // reset exactly when a marker is due
        for (int i = 0; i < 4; i++) step(0, 1, 1, rnd_blk());
        step(1, 1, 1, rnd_blk());
        chk("rst_due_v", 66'(ov[0]), 66'(0));
        chk("rst_due_f", 66'(af[0]), 66'(0));
        step(0, 1, 0, zb);
        chk("after_rst_am", 66'(af[0]), 66'(1));
        chk("after_rst_bip", 66'(od[0][39:32]), 66'h0);
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 19) != 0), 1'($urandom), rnd_blk());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
